picorv32_wb_bridge: RTL and testbench

Converts the picorv32 native memory interface (valid/ready, byte strobes) into the single-master Wishbone-classic `core_*` bus consumed by the ProcessorCI Controller. It sits between the `picorv32` instance and the `core_*` ports in `processorci_top`. It registers every bus output, holds one outstanding transfer, and aborts stalled transfers with a bus-timeout error.

---
 rtl/picorv32_wb_pkg.sv | 17 +
 rtl/bus_timeout_counter.sv | 36 +++
 rtl/picorv32_wb_bridge.sv | 155 +++++++++++++++
 tb/tb_picorv32_wb_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_wb_pkg.sv
// Shared types and constants for the picorv32 to Wishbone-classic bridge.
package picorv32_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0]  SEL_ALL      = 4'hF;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    function automatic int tmo_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts enabled cycles and flags the last one before the limit is reached.
module bus_timeout_counter
    import picorv32_wb_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int W = tmo_width(LIMIT);
            logic [W-1:0] r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + W'(1);
                end
            end

            // High during the cycle whose closing edge completes LIMIT cycles
            assign expired = enable && (r_count == W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory port to single-master Wishbone-classic bridge
// with one outstanding transfer and a sticky bus-timeout error.
module picorv32_wb_bridge
    import picorv32_wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF,
    parameter bit          PIPELINED      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        core_cyc,
    output logic        core_stb,
    output logic        core_we,
    output logic [3:0]  core_sel,
    output logic [31:0] core_addr,
    output logic [31:0] core_data_out,
    input  logic [31:0] core_data_in,
    input  logic        core_ack,
    input  logic        err_clr,
    output logic        bus_error,
    output logic [31:0] err_addr,
    output logic        err_instr
);

    state_e      r_state;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [29:0] r_addr_hi;
    logic [1:0]  r_addr_lo;
    logic        r_instr;
    logic [31:0] r_dout;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_err_addr;
    logic        r_err_instr;

    logic w_start;
    logic w_in_bus;
    logic w_expired;
    logic w_abort;

    assign w_start  = (r_state == ST_IDLE) && mem_valid;
    assign w_in_bus = (r_state == ST_BUS);
    assign w_abort  = w_in_bus && !core_ack && w_expired;

    bus_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_start),
        .enable (w_in_bus),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_addr_hi <= '0;
            r_addr_lo <= '0;
            r_instr   <= 1'b0;
            r_dout    <= '0;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        r_state   <= ST_BUS;
                        r_addr_hi <= mem_addr[31:2];
                        r_addr_lo <= mem_addr[1:0];
                        r_instr   <= mem_instr;
                        r_dout    <= mem_wdata;
                        r_we      <= |mem_wstrb;
                        r_sel     <= (|mem_wstrb) ? mem_wstrb : SEL_ALL;
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (PIPELINED) begin
                        r_stb <= 1'b0;
                    end
                    // Ack takes priority over an expiring timeout
                    if (core_ack) begin
                        r_state <= ST_RESP;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_rdata <= r_we ? 32'h0 : core_data_in;
                    end else if (w_expired) begin
                        r_state <= ST_RESP;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_rdata <= r_we ? 32'h0 : ERR_DATA;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_err_addr  <= '0;
            r_err_instr <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_err_addr  <= {r_addr_hi, r_addr_lo};
                r_err_instr <= r_instr;
            end
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign mem_ready     = r_ready;
    assign mem_rdata     = r_rdata;
    assign core_cyc      = r_cyc;
    assign core_stb      = r_stb;
    assign core_we       = r_we;
    assign core_sel      = r_sel;
    assign core_addr     = {r_addr_hi, 2'b00};
    assign core_data_out = r_dout;
    assign bus_error     = r_err;
    assign err_addr      = r_err_addr;
    assign err_instr     = r_err_instr;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Randomized bench for picorv32_wb_bridge against a transaction-level model.
module tb_picorv32_wb_bridge;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] core_data_in;
    logic        core_ack;
    logic        err_clr;

    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        core_cyc;
    logic        core_stb;
    logic        core_we;
    logic [3:0]  core_sel;
    logic [31:0] core_addr;
    logic [31:0] core_data_out;
    logic        bus_error;
    logic [31:0] err_addr;
    logic        err_instr;

    logic        d2_ready;
    logic [31:0] d2_rdata;
    logic        d2_cyc;
    logic        d2_stb;
    logic        d2_we;
    logic [3:0]  d2_sel;
    logic [31:0] d2_addr;
    logic [31:0] d2_dout;
    logic        d2_err;
    logic [31:0] d2_err_addr;
    logic        d2_err_instr;

    int n_chk = 0;
    int n_err = 0;

    logic        m_err;
    logic [31:0] m_err_addr;
    logic        m_err_instr;

    picorv32_wb_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (32'hDEAD_BEEF),
        .PIPELINED     (1'b1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .core_cyc     (core_cyc),
        .core_stb     (core_stb),
        .core_we      (core_we),
        .core_sel     (core_sel),
        .core_addr    (core_addr),
        .core_data_out(core_data_out),
        .core_data_in (core_data_in),
        .core_ack     (core_ack),
        .err_clr      (err_clr),
        .bus_error    (bus_error),
        .err_addr     (err_addr),
        .err_instr    (err_instr)
    );

    picorv32_wb_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (32'hDEAD_BEEF),
        .PIPELINED     (1'b0)
    ) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (d2_ready),
        .mem_rdata    (d2_rdata),
        .core_cyc     (d2_cyc),
        .core_stb     (d2_stb),
        .core_we      (d2_we),
        .core_sel     (d2_sel),
        .core_addr    (d2_addr),
        .core_data_out(d2_dout),
        .core_data_in (core_data_in),
        .core_ack     (core_ack),
        .err_clr      (err_clr),
        .bus_error    (d2_err),
        .err_addr     (d2_err_addr),
        .err_instr    (d2_err_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU transfer; ack_dly < 0 means the slave never acks.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr,
                        input int ack_dly, input logic [31:0] sdata, input bit clr);
        bit          tmo;
        int          exp_cyc;
        int          n;
        int          cyc_n;
        int          stb_n;
        int          stb2_n;
        logic        got;
        logic [31:0] exp_rd;
        tmo     = (ack_dly < 0) || (ack_dly + 1 > TMO);
        exp_cyc = tmo ? TMO : ack_dly + 1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = instr;
        core_ack  = 1'b0;
        @(posedge clk); #1;
        check("bus_addr", core_addr, {addr[31:2], 2'b00});
        check("bus_sel", {28'h0, core_sel}, {28'h0, (wstrb != 0) ? wstrb : 4'hF});
        check("bus_we", {31'h0, core_we}, {31'h0, wstrb != 0});
        check("bus_dout", core_data_out, wdata);
        n = 0; cyc_n = 0; stb_n = 0; stb2_n = 0; got = 1'b0;
        err_clr = clr;
        while (n < 40 && !got) begin
            cyc_n += int'(core_cyc);
            stb_n += int'(core_stb);
            stb2_n += int'(d2_stb);
            core_ack     = (ack_dly >= 0) && (n == ack_dly);
            core_data_in = core_ack ? sdata : $urandom;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
            mem_instr = 1'($urandom);
            @(posedge clk); #1;
            n++;
            got = mem_ready;
        end
        err_clr  = 1'b0;
        core_ack = 1'b0;
        check("latency", n, exp_cyc);
        check("cyc_cycles", cyc_n, exp_cyc);
        check("stb_pipe", stb_n, 1);
        check("stb_classic", stb2_n, exp_cyc);
        check("ready2", {31'h0, d2_ready}, 32'h1);
        exp_rd = (wstrb != 0) ? 32'h0 : (tmo ? 32'hDEAD_BEEF : sdata);
        check("rdata", mem_rdata, exp_rd);
        check("rdata2", d2_rdata, exp_rd);
        if (tmo) begin
            if (!m_err || clr) begin
                m_err_addr  = addr;
                m_err_instr = instr;
            end
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
        check("bus_error", {31'h0, bus_error}, {31'h0, m_err});
        check("err_addr", err_addr, m_err_addr);
        check("err_instr", {31'h0, err_instr}, {31'h0, m_err_instr});
        check("cyc_resp", {31'h0, core_cyc}, 32'h0);
        mem_valid = 1'b0;
        mem_addr  = $urandom;
        @(posedge clk); #1;
        check("ready_pulse", {31'h0, mem_ready}, 32'h0);
        check("cyc_idle", {31'h0, core_cyc}, 32'h0);
    endtask

    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            core_ack     = 1'($urandom);
            core_data_in = $urandom;
            @(posedge clk); #1;
            check("idle_ready", {31'h0, mem_ready}, 32'h0);
            check("idle_cyc", {31'h0, core_cyc}, 32'h0);
        end
        core_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("err_clr", {31'h0, bus_error}, 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_valid    = 1'b0;
        mem_instr    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        core_data_in = '0;
        core_ack     = 1'b0;
        err_clr      = 1'b0;
        m_err        = 1'b0;
        m_err_addr   = '0;
        m_err_instr  = 1'b0;
        #1;
        check("rst_cyc", {31'h0, core_cyc}, 32'h0);
        check("rst_stb", {31'h0, core_stb}, 32'h0);
        check("rst_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_addr", core_addr, 32'h0);
        check("rst_err", {31'h0, bus_error}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        xfer(32'h0000_1006, 32'h0, 4'h0, 1'b1, 0, 32'h1234_5678, 1'b0);
        xfer(32'h0000_2000, 32'h00AB_0000, 4'b0100, 1'b0, 2, 32'hFFFF_FFFF, 1'b0);
        xfer(32'h0000_3008, 32'h0, 4'h0, 1'b0, 5, 32'hCAFE_F00D, 1'b0);
        xfer(32'h2000_0013, 32'h0, 4'h0, 1'b1, -1, 32'h0, 1'b0);
        xfer(32'h3000_0000, 32'h5555_AAAA, 4'hF, 1'b0, -1, 32'h0, 1'b0);
        pulse_clr();
        xfer(32'h0000_4004, 32'h0, 4'h0, 1'b0, TMO - 1, 32'h0BAD_CAFE, 1'b0);

        mem_valid = 1'b1;
        mem_addr  = 32'h0000_5000;
        mem_wstrb = 4'h0;
        @(posedge clk); #1;
        check("pre_rst_cyc", {31'h0, core_cyc}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_cyc", {31'h0, core_cyc}, 32'h0);
        check("async_stb", {31'h0, core_stb}, 32'h0);
        mem_valid = 1'b0;
        m_err = 1'b0;
        m_err_addr = '0;
        m_err_instr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_gap(3);
        xfer(32'h0000_5000, 32'h0, 4'h0, 1'b0, 1, 32'h7777_1111, 1'b0);

        for (int t = 0; t < 60; t++) begin
            int   dly;
            logic [3:0] ws;
            dly = $urandom_range(0, 12);
            if (dly == 12) dly = -1;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            xfer($urandom, $urandom, ws, 1'($urandom), dly, $urandom,
                 $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pulse_clr();
            idle_gap($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
